multicycle_proc_controller: RTL
===============================

// Module: multicycle_proc_controller
// PURPOSE
//  Multi-cycle successor to the single-cycle controller: same ISA and datapath mux selects,
//  but sequenced by an FSM over FETCH/DECODE/EXEC/MEM/WB. Owns the instruction register (IR)
//  and a valid/ack handshake to a shared instruction/data memory of variable latency.
//  Sits between the memory port and the datapath (PC, regfile, ALU); traps illegal opcodes.
// PARAMETERS
//  REG_IDX_W  4   register index width; regfile depth = 2**REG_IDX_W
//  IMM_W      16  immediate field width
//  INSTR_W    8+IMM_W+2*REG_IDX_W (32)  derived; do not override
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous reset, active-low
//  instrIn       in   INSTR_W  memory read data; captured into IR on fetch ack
//  memAck        in   1        memory completes current request (same-cycle ack legal)
//  aluOut        in   1        ALU bit 0; branch-taken condition
//  memRdReq      out  1        memory read request, held until memAck
//  memWrEn       out  1        memory write request, held until memAck
//  memAddrSel    out  1        0 = PC, 1 = ALU result
//  irWrEn        out  1        IR load strobe, mirrors the internal IR capture
//  pcWrEn        out  1        PC update strobe; exactly one pulse per retired instruction
//  pcSel         out  2        00 PC+4, 01 PC+4+IMM*4, 10 RS1+IMM
//  regFileWrEn   out  1        regfile write strobe
//  regFileWrSel  out  2        00 ALU, 01 MEM, 10 PC+4
//  aluSrc2Sel    out  1        0 RS2, 1 IMM
//  aluAltOp      out  1        1 selects compare-function table
//  aluFunc       out  4        IR[7:4]
//  imm           out  IMM_W    IR[8+IMM_W-1:8]
//  regFileRd0Index / regFileRd1Index / regFileWrIndex  out  REG_IDX_W  read/write indices
//  illegalInstr  out  1        sticky trap flag
// BEHAVIOUR
//  Fields: op=IR[3:0]; rd=top REG_IDX_W bits; rs1=next REG_IDX_W; rs2=top REG_IDX_W bits of imm.
//  Opcodes: ALU-R 0000, ALU-I 1000, CMP-R 0010, CMP-I 1010, BRANCH 0110, STORE 0101,
//   LOAD 1001, JAL 1011; all others illegal. STORE/BRANCH read rd,rs1 as Rd0,Rd1; others Rd0=rs1.
//  Reset (async): state=FETCH, IR=0, illegalInstr=0; all strobes/requests forced 0 while rst_n=0.
//  FETCH: memRdReq=1, memAddrSel=0; on memAck irWrEn=1, IR<=instrIn, ->DECODE; else stay.
//  DECODE: indices driven from IR; illegal op -> TRAP; else ->EXEC. No strobes.
//  EXEC: aluSrc2Sel/aluAltOp per class (CMP, BRANCH: aluAltOp=1).
//   BRANCH: pcWrEn=1, pcSel=aluOut?01:00, ->FETCH.  LOAD/STORE: ->MEM.  others: ->WB.
//  MEM: memAddrSel=1; LOAD memRdReq=1, STORE memWrEn=1, held until memAck.
//   On ack: LOAD ->WB; STORE pcWrEn=1 pcSel=00 ->FETCH.
//  WB: regFileWrEn=1; regFileWrSel ALU (ALU/CMP), MEM (LOAD), PC4 (JAL); pcWrEn=1;
//   pcSel=10 for JAL else 00; ->FETCH. JAL links old PC+4 (PC not yet updated).
//  TRAP: illegalInstr=1, no strobes/requests; exit only via reset.
//  Latency with zero-wait memory (cycles FETCH..last): BRANCH 3, ALU/CMP/JAL/STORE 4, LOAD 5;
//   each memory wait cycle adds one. memAck outside an active request is ignored.
//  Never memRdReq and memWrEn together; regFileWrEn only in WB; at most one pcWrEn per instr.
//  Reset mid-request: request drops immediately, no write strobe issued; restart at FETCH.
// STRUCTURE
//  proc_ctrl_pkg: opcode constants, state encoding, pcSel/regFileWrSel/aluSrc2Sel constants.
//  Sub-module proc_ctrl_decode: combinational IR -> instruction class, illegal flag, indices.
//  Top: state register, IR register, output decode of (state, class, memAck, aluOut).
// TESTING
//  ALU-R add r3=r1+r2, memAck=1 always -> 4 cycles, WB regFileWrEn=1 Sel=00 WrIndex=3, pcSel=00.
//  LOAD with 3 wait cycles in MEM -> memRdReq held 4 cycles, memAddrSel=1, WB Sel=01, total 8.
//  BRANCH aluOut=1 then aluOut=0 -> EXEC pcWrEn=1 pcSel=01 then 00; no regFileWrEn ever.
//  JAL rd=15 rs1=2 -> WB regFileWrEn=1 Sel=10 WrIndex=15, pcSel=10, single pcWrEn.
//  Opcode 0011 -> TRAP after DECODE, illegalInstr=1 sticky, no strobes for 20 cycles; rst_n clears.
//  rst_n low mid STORE MEM wait -> memWrEn=0 at once; after release first cycle is FETCH, IR=0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// proc_ctrl_pkg
// Shared definitions for the multi-cycle processor controller:
//   - opcode constants of the ISA
//   - FSM state encoding
//   - datapath mux select constants (pcSel, regFileWrSel, aluSrc2Sel)
//   - classify(): opcode -> instruction class flags
// ---------------------------------------------------------------------------
package proc_ctrl_pkg;

    // Opcodes (IR[3:0])
    localparam logic [3:0] OP_ALU_R  = 4'b0000;
    localparam logic [3:0] OP_ALU_I  = 4'b1000;
    localparam logic [3:0] OP_CMP_R  = 4'b0010;
    localparam logic [3:0] OP_CMP_I  = 4'b1010;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_STORE  = 4'b0101;
    localparam logic [3:0] OP_LOAD   = 4'b1001;
    localparam logic [3:0] OP_JAL    = 4'b1011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrlState_t;

    // pcSel encodings
    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_REG    = 2'b10;

    // regFileWrSel encodings
    localparam logic [1:0] WR_SEL_ALU = 2'b00;
    localparam logic [1:0] WR_SEL_MEM = 2'b01;
    localparam logic [1:0] WR_SEL_PC4 = 2'b10;

    // aluSrc2Sel encodings
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    typedef struct packed {
        logic isCmp;
        logic isBranch;
        logic isStore;
        logic isLoad;
        logic isJal;
        logic useImm;   // second ALU operand is the immediate
        logic illegal;
    } instrClass_t;

    // LOAD/STORE need the immediate for address generation; JAL forms
    // RS1+IMM, so it also selects the immediate.
    function automatic instrClass_t classify(input logic [3:0] op);
        instrClass_t c;
        c = '0;
        case (op)
            OP_ALU_R:  c = '0;
            OP_ALU_I:  c.useImm = 1'b1;
            OP_CMP_R:  c.isCmp = 1'b1;
            OP_CMP_I:  begin c.isCmp = 1'b1; c.useImm = 1'b1; end
            OP_BRANCH: c.isBranch = 1'b1;
            OP_STORE:  begin c.isStore = 1'b1; c.useImm = 1'b1; end
            OP_LOAD:   begin c.isLoad = 1'b1; c.useImm = 1'b1; end
            OP_JAL:    begin c.isJal = 1'b1; c.useImm = 1'b1; end
            default:   c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// proc_ctrl_decode
// Combinational instruction decode of the IR.
// IR layout (MSB..LSB): rd | rs1 | imm | func | op
//   rs2 is the top REG_IDX_W bits of imm.
// Ports:
//   ir         in   INSTR_W    instruction register contents
//   isCmp .. isJal, useImm     instruction class flags
//   isIllegal  out  1          opcode not in the ISA
//   rd0Index   out  REG_IDX_W  regfile read port 0 index
//   rd1Index   out  REG_IDX_W  regfile read port 1 index
//   wrIndex    out  REG_IDX_W  regfile write index (rd)
// ---------------------------------------------------------------------------
module proc_ctrl_decode
    import proc_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 4,
    parameter int IMM_W     = 16,
    localparam int INSTR_W  = 8 + IMM_W + 2 * REG_IDX_W
) (
    input  logic [INSTR_W-1:0]   ir,
    output logic                 isCmp,
    output logic                 isBranch,
    output logic                 isStore,
    output logic                 isLoad,
    output logic                 isJal,
    output logic                 useImm,
    output logic                 isIllegal,
    output logic [REG_IDX_W-1:0] rd0Index,
    output logic [REG_IDX_W-1:0] rd1Index,
    output logic [REG_IDX_W-1:0] wrIndex
);

    logic [REG_IDX_W-1:0] rdField;
    logic [REG_IDX_W-1:0] rs1Field;
    logic [REG_IDX_W-1:0] rs2Field;
    instrClass_t          cls;

    assign rdField  = ir[INSTR_W-1 -: REG_IDX_W];
    assign rs1Field = ir[INSTR_W-REG_IDX_W-1 -: REG_IDX_W];
    assign rs2Field = ir[8+IMM_W-1 -: REG_IDX_W];

    assign cls = classify(ir[3:0]);

    assign isCmp     = cls.isCmp;
    assign isBranch  = cls.isBranch;
    assign isStore   = cls.isStore;
    assign isLoad    = cls.isLoad;
    assign isJal     = cls.isJal;
    assign useImm    = cls.useImm;
    assign isIllegal = cls.illegal;

    // STORE (data) and BRANCH (compare) read rd as a source operand.
    assign rd0Index = (cls.isStore || cls.isBranch) ? rdField  : rs1Field;
    assign rd1Index = (cls.isStore || cls.isBranch) ? rs1Field : rs2Field;
    assign wrIndex  = rdField;

endmodule

// File: rtl/multicycle_proc_controller.sv
// ---------------------------------------------------------------------------
// multicycle_proc_controller
// FSM sequencer FETCH -> DECODE -> EXEC -> [MEM] -> [WB] for the processor
// datapath. Owns the IR and the valid/ack handshake to the shared memory.
// Illegal opcodes park the FSM in TRAP until reset.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   instrIn                memory read data, captured into IR on fetch ack
//   memAck                 memory request completion (same-cycle legal)
//   aluOut                 ALU bit 0, branch-taken condition
//   memRdReq, memWrEn      memory read / write request, held until memAck
//   memAddrSel             0 = PC, 1 = ALU result
//   irWrEn                 IR load strobe
//   pcWrEn, pcSel          PC update strobe and next-PC select
//   regFileWrEn/WrSel      regfile write strobe and write-data select
//   aluSrc2Sel, aluAltOp   ALU operand-2 select, compare-table select
//   aluFunc, imm           IR function and immediate fields
//   regFileRd0/Rd1/WrIndex regfile indices
//   illegalInstr           sticky trap flag
// ---------------------------------------------------------------------------
module multicycle_proc_controller
    import proc_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 4,
    parameter int IMM_W     = 16,
    localparam int INSTR_W  = 8 + IMM_W + 2 * REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W-1:0]   instrIn,
    input  logic                 memAck,
    input  logic                 aluOut,
    output logic                 memRdReq,
    output logic                 memWrEn,
    output logic                 memAddrSel,
    output logic                 irWrEn,
    output logic                 pcWrEn,
    output logic [1:0]           pcSel,
    output logic                 regFileWrEn,
    output logic [1:0]           regFileWrSel,
    output logic                 aluSrc2Sel,
    output logic                 aluAltOp,
    output logic [3:0]           aluFunc,
    output logic [IMM_W-1:0]     imm,
    output logic [REG_IDX_W-1:0] regFileRd0Index,
    output logic [REG_IDX_W-1:0] regFileRd1Index,
    output logic [REG_IDX_W-1:0] regFileWrIndex,
    output logic                 illegalInstr
);

    ctrlState_t         stateReg;
    ctrlState_t         stateNext;
    logic [INSTR_W-1:0] irReg;
    logic               irCapture;

    logic isCmp, isBranch, isStore, isLoad, isJal, useImm, isIllegal;

    proc_ctrl_decode #(
        .REG_IDX_W (REG_IDX_W),
        .IMM_W     (IMM_W)
    ) u_decode (
        .ir        (irReg),
        .isCmp     (isCmp),
        .isBranch  (isBranch),
        .isStore   (isStore),
        .isLoad    (isLoad),
        .isJal     (isJal),
        .useImm    (useImm),
        .isIllegal (isIllegal),
        .rd0Index  (regFileRd0Index),
        .rd1Index  (regFileRd1Index),
        .wrIndex   (regFileWrIndex)
    );

    assign aluFunc = irReg[7:4];
    assign imm     = irReg[8+IMM_W-1:8];

    assign irCapture = (stateReg == ST_FETCH) && memAck;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= ST_FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irReg <= '0;
        end else if (irCapture) begin
            irReg <= instrIn;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_FETCH:  if (memAck) stateNext = ST_DECODE;
            ST_DECODE: stateNext = isIllegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (isBranch)               stateNext = ST_FETCH;
                else if (isLoad || isStore) stateNext = ST_MEM;
                else                        stateNext = ST_WB;
            end
            ST_MEM:    if (memAck) stateNext = isLoad ? ST_WB : ST_FETCH;
            ST_WB:     stateNext = ST_FETCH;
            ST_TRAP:   stateNext = ST_TRAP;
            default:   stateNext = ST_FETCH;
        endcase
    end

    // Output logic. Everything is held at zero while rst_n is low so that a
    // request interrupted by reset drops in the same cycle.
    always_comb begin
        memRdReq     = 1'b0;
        memWrEn      = 1'b0;
        memAddrSel   = 1'b0;
        irWrEn       = 1'b0;
        pcWrEn       = 1'b0;
        pcSel        = PC_SEL_PC4;
        regFileWrEn  = 1'b0;
        regFileWrSel = WR_SEL_ALU;
        aluSrc2Sel   = SRC2_RS2;
        aluAltOp     = 1'b0;
        illegalInstr = 1'b0;
        if (rst_n) begin
            // ALU operand selects stay valid from EXEC through WB so the ALU
            // result feeding the memory address / write-back stays stable.
            if (stateReg == ST_EXEC || stateReg == ST_MEM || stateReg == ST_WB) begin
                aluSrc2Sel = useImm ? SRC2_IMM : SRC2_RS2;
                aluAltOp   = isCmp || isBranch;
            end
            case (stateReg)
                ST_FETCH: begin
                    memRdReq = 1'b1;
                    irWrEn   = irCapture;
                end
                ST_EXEC: begin
                    if (isBranch) begin
                        pcWrEn = 1'b1;
                        pcSel  = aluOut ? PC_SEL_BRANCH : PC_SEL_PC4;
                    end
                end
                ST_MEM: begin
                    memAddrSel = 1'b1;
                    memRdReq   = isLoad;
                    memWrEn    = isStore;
                    if (isStore && memAck) begin
                        pcWrEn = 1'b1;
                    end
                end
                ST_WB: begin
                    regFileWrEn  = 1'b1;
                    regFileWrSel = isLoad ? WR_SEL_MEM : (isJal ? WR_SEL_PC4 : WR_SEL_ALU);
                    pcWrEn       = 1'b1;
                    pcSel        = isJal ? PC_SEL_REG : PC_SEL_PC4;
                end
                ST_TRAP:  illegalInstr = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule
